// File: rtl/xz_tracker_pkg.sv
// Shared types and 4-state reduction helpers for the X/Z parity tracker.
// Reductions take a MAX_W-wide word plus the live width so any channel width up to MAX_W fits.
package xz_tracker_pkg;

   localparam int unsigned MAX_W     = 64;
   localparam int unsigned REC_NCH   = 4;
   localparam int unsigned REC_SEQ_W = 4;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      CLEAR
   } state_e;

   typedef struct packed {
      logic [REC_NCH-1:0]   par;
      logic [REC_NCH-1:0]   xz;
      logic [REC_SEQ_W-1:0] seq;
   } record_t;

   function automatic logic is_xz(input logic [MAX_W-1:0] v, input int unsigned n);
      logic [MAX_W-1:0] t;
      logic             f;
      t = v;
      f = 1'b0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < n && $isunknown(t[0])) f = 1'b1;
         t = t >> 1;
      end
      return f;
   endfunction

   // X/Z bits count as 0: only a definite 1 toggles the result.
   function automatic logic red_xor(input logic [MAX_W-1:0] v, input int unsigned n);
      logic [MAX_W-1:0] t;
      logic             acc;
      t   = v;
      acc = 1'b0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < n) acc = acc ^ (t[0] === 1'b1);
         t = t >> 1;
      end
      return acc;
   endfunction

   // X/Z bits count as 1: only a definite 0 breaks the AND term.
   function automatic logic red_nand(input logic [MAX_W-1:0] v, input int unsigned n);
      logic [MAX_W-1:0] t;
      logic             all_one;
      t       = v;
      all_one = 1'b1;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < n) all_one = all_one & (t[0] !== 1'b0);
         t = t >> 1;
      end
      return ~all_one;
   endfunction

endpackage

// File: rtl/xz_parity_tracker_if.sv
// Beat-in / record-out handshake bundle of the X/Z parity tracker.
// slave is the tracker side, master is the producer/consumer side.
interface xz_parity_tracker_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned W     = 9,
   parameter int unsigned SEQ_W = 4
) ();

   logic                    mode;
   logic                    in_valid;
   logic                    in_ready;
   logic [NCH-1:0][W-1:0]   in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [NCH-1:0]          out_par;
   logic [NCH-1:0]          out_xz;
   logic [SEQ_W-1:0]        out_seq;

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_par, out_xz, out_seq
   );

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_par, out_xz, out_seq
   );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata shows the head entry whenever empty is low.
// Pushes while full and pops while empty are dropped.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer MSB tells a full ring from an empty one.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wdata;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/xz_parity_tracker.sv
// Multi-channel 4-state bus monitor: reduces each accepted beat to per-channel parity and X/Z flags,
// buffers the records in a FWFT FIFO and keeps saturating per-channel X/Z counters.
module xz_parity_tracker
   import xz_tracker_pkg::*;
#(
   parameter int unsigned NCH   = REC_NCH,
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned SEQ_W = REC_SEQ_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   xz_parity_tracker_if.slave         bus,
   output logic [NCH-1:0][CNT_W-1:0]  xz_cnt,
   output logic                       busy
);

   localparam int unsigned REC_W = $bits(record_t);

   state_e                    state_q, state_d;
   logic [SEQ_W-1:0]          seq_q, seq_d;
   logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   logic           full, empty;
   logic           accept, pop;
   logic [NCH-1:0] beat_par, beat_xz;
   record_t        push_rec, head_rec;

   assign bus.in_ready  = (state_q == RUN) && !full;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = !empty;
   assign pop           = !empty && bus.out_ready;

   always_comb begin
      beat_par = '0;
      beat_xz  = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         beat_xz[c]  = is_xz(MAX_W'(bus.in_data[c]), W);
         beat_par[c] = bus.mode ? red_nand(MAX_W'(bus.in_data[c]), W)
                                : red_xor(MAX_W'(bus.in_data[c]), W);
      end
   end

   assign push_rec = '{par: beat_par, xz: beat_xz, seq: seq_q};

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (push_rec),
      .pop   (pop),
      .rdata (head_rec),
      .full  (full),
      .empty (empty)
   );

   // FIFO contents are stale when empty, so the visible record is forced to zero.
   assign bus.out_par = empty ? '0 : head_rec.par;
   assign bus.out_xz  = empty ? '0 : head_rec.xz;
   assign bus.out_seq = empty ? '0 : head_rec.seq;

   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (empty) state_d = CLEAR;
         CLEAR:   state_d = RUN;
         default: state_d = RUN;
      endcase
      if (accept) begin
         seq_d = seq_q + SEQ_W'(1);
         for (int unsigned c = 0; c < NCH; c++) begin
            if (beat_xz[c] && (cnt_q[c] != '1)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
         end
      end
      if (state_q == CLEAR) begin
         seq_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         seq_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         cnt_q   <= cnt_d;
      end
   end

   assign xz_cnt = cnt_q;
   assign busy   = (state_q != RUN) || !empty;

endmodule

// File: tb/tb_xz_parity_tracker.sv
// Directed self-checking bench for xz_parity_tracker (NCH=4, W=9, DEPTH=4, CNT_W=2, SEQ_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_xz_parity_tracker;

   logic                clk;
   logic                rst;
   logic                flush;
   logic [3:0][1:0]     xz_cnt;
   logic                busy;

   int checks   = 0;
   int failures = 0;

   // X/Z patterns live in variables so the driven value and the expected value share one source.
   logic [8:0] x_word;
   logic [8:0] ch1_x;
   logic [8:0] ch1_z;

   xz_parity_tracker_if #(.NCH(4), .W(9), .SEQ_W(4)) bus ();

   xz_parity_tracker #(
      .NCH   (4),
      .W     (9),
      .DEPTH (4),
      .CNT_W (2),
      .SEQ_W (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .bus    (bus.slave),
      .xz_cnt (xz_cnt),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected gate behaviour: XOR treats X/Z as 0, NAND treats X/Z as 1.
   function automatic logic bench_par(input logic m, input logic [8:0] v);
      logic acc;
      logic all_one;
      acc     = 1'b0;
      all_one = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (v[i] === 1'b1) acc = ~acc;
         if (v[i] === 1'b0) all_one = 1'b0;
      end
      return m ? ~all_one : acc;
   endfunction

   function automatic logic bench_xz(input logic [8:0] v);
      logic f;
      f = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (v[i] !== 1'b0 && v[i] !== 1'b1) f = 1'b1;
      end
      return f;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.mode      = 1'b0;
      bus.in_data   = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
      checks++; if (bus.out_par !== 4'h0) begin failures++; $display("FAIL reset_out_par: got %0h want 0", bus.out_par); end
      checks++; if (bus.out_xz !== 4'h0) begin failures++; $display("FAIL reset_out_xz: got %0h want 0", bus.out_xz); end
      checks++; if (bus.out_seq !== 4'h0) begin failures++; $display("FAIL reset_out_seq: got %0h want 0", bus.out_seq); end
      checks++; if (xz_cnt !== 8'h00) begin failures++; $display("FAIL reset_xz_cnt: got %0h want 0", xz_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
   endtask

   task automatic test_xor();
      logic p1, x1;
      p1 = bench_par(1'b0, ch1_x);
      x1 = bench_xz(ch1_x);
      bus.mode       = 1'b0;
      bus.in_data    = '0;
      bus.in_data[0] = 9'b000000111;
      bus.in_data[1] = ch1_x;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL xor_out_valid: got %0b want 1", bus.out_valid); end
      checks++; if (bus.out_par !== {2'b00, p1, 1'b1}) begin failures++; $display("FAIL xor_out_par: got %0b want %0b", bus.out_par, {2'b00, p1, 1'b1}); end
      checks++; if (bus.out_xz !== {2'b00, x1, 1'b0}) begin failures++; $display("FAIL xor_out_xz: got %0b want %0b", bus.out_xz, {2'b00, x1, 1'b0}); end
      checks++; if (bus.out_seq !== 4'd0) begin failures++; $display("FAIL xor_out_seq: got %0d want 0", bus.out_seq); end
      checks++; if (xz_cnt[1] !== {1'b0, x1}) begin failures++; $display("FAIL xor_xz_cnt1: got %0d want %0d", xz_cnt[1], x1); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL xor_busy: got %0b want 1", busy); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL xor_popped_valid: got %0b want 0", bus.out_valid); end
      checks++; if (bus.out_seq !== 4'd0 || bus.out_par !== 4'h0) begin failures++; $display("FAIL xor_idle_zero: got seq %0d par %0h want 0 0", bus.out_seq, bus.out_par); end
   endtask

   task automatic test_nand();
      logic p1, x1, xa;
      logic [1:0] cnt_exp;
      p1 = bench_par(1'b1, ch1_z);
      x1 = bench_xz(ch1_z);
      xa = bench_xz(ch1_x);
      cnt_exp = {1'b0, xa} + {1'b0, x1};
      bus.mode       = 1'b1;
      bus.in_data    = '0;
      bus.in_data[0] = 9'h1FF;
      bus.in_data[1] = ch1_z;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_par !== {1'b1, 1'b1, p1, 1'b0}) begin failures++; $display("FAIL nand_out_par: got %0b want %0b", bus.out_par, {1'b1, 1'b1, p1, 1'b0}); end
      checks++; if (bus.out_xz !== {2'b00, x1, 1'b0}) begin failures++; $display("FAIL nand_out_xz: got %0b want %0b", bus.out_xz, {2'b00, x1, 1'b0}); end
      checks++; if (bus.out_seq !== 4'd1) begin failures++; $display("FAIL nand_out_seq: got %0d want 1", bus.out_seq); end
      checks++; if (xz_cnt[1] !== cnt_exp) begin failures++; $display("FAIL nand_xz_cnt1: got %0d want %0d", xz_cnt[1], cnt_exp); end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.mode      = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [4:0] par_tab;
      par_tab = 5'b10110;
      do_reset();
      bus.mode     = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_data    = '0;
         bus.in_data[0] = 9'(i);
         checks++; if (bus.in_ready !== (i < 4)) begin failures++; $display("FAIL bp_in_ready_%0d: got %0b want %0b", i, bus.in_ready, (i < 4)); end
         tick();
      end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %0b want 0", bus.in_ready); end
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_%0d: got %0b want 1", k, bus.out_valid); end
         checks++; if (bus.out_seq !== 4'(k)) begin failures++; $display("FAIL bp_seq_%0d: got %0d want %0d", k, bus.out_seq, k); end
         checks++; if (bus.out_par[0] !== par_tab[k]) begin failures++; $display("FAIL bp_par_%0d: got %0b want %0b", k, bus.out_par[0], par_tab[k]); end
         if (k == 0) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_popthrough: got %0b want 0", bus.in_ready); end
         end
         if (k == 1) begin
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_again: got %0b want 1", bus.in_ready); end
         end
         if (k == 2) bus.in_valid = 1'b0;
         tick();
      end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %0b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic xe, pe;
      xe = bench_xz(x_word);
      pe = bench_par(1'b0, x_word);
      do_reset();
      bus.mode      = 1'b0;
      bus.in_data   = {4{x_word}};
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid_%0d: got %0b want 1", k, bus.out_valid); end
         checks++; if (bus.out_seq !== 4'(k)) begin failures++; $display("FAIL b2b_seq_%0d: got %0d want %0d", k, bus.out_seq, 4'(k)); end
         if (k == 0) begin
            checks++; if (bus.out_xz !== {4{xe}}) begin failures++; $display("FAIL b2b_xz: got %0b want %0b", bus.out_xz, {4{xe}}); end
            checks++; if (bus.out_par !== {4{pe}}) begin failures++; $display("FAIL b2b_par: got %0b want %0b", bus.out_par, {4{pe}}); end
         end
         if (k == 16) bus.in_valid = 1'b0;
      end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got %0b want 0", bus.out_valid); end
      checks++; if (xz_cnt !== {4{xe, xe}}) begin failures++; $display("FAIL b2b_saturate: got %0h want %0h", xz_cnt, {4{xe, xe}}); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_flush();
      logic xe;
      xe = bench_xz(x_word);
      do_reset();
      bus.mode     = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_data    = '0;
         bus.in_data[0] = 9'(i + 1);
         bus.in_data[3] = x_word;
         tick();
      end
      bus.in_data[0] = 9'h004;
      flush          = 1'b1;
      bus.out_ready  = 1'b1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_run_ready: got %0b want 1", bus.in_ready); end
      checks++; if (bus.out_seq !== 4'd0) begin failures++; $display("FAIL flush_head_seq: got %0d want 0", bus.out_seq); end
      tick();
      flush = 1'b0;
      for (int k = 1; k < 4; k++) begin
         checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL flush_drain_%0d: got ready %0b busy %0b want 0 1", k, bus.in_ready, busy); end
         checks++; if (bus.out_seq !== 4'(k)) begin failures++; $display("FAIL flush_seq_%0d: got %0d want %0d", k, bus.out_seq, k); end
         tick();
      end
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_drain_empty: got valid %0b busy %0b ready %0b want 0 1 0", bus.out_valid, busy, bus.in_ready); end
      tick();
      checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_clear_state: got busy %0b ready %0b want 1 0", busy, bus.in_ready); end
      checks++; if (xz_cnt[3] !== {xe, xe}) begin failures++; $display("FAIL flush_cnt_before: got %0d want %0d", xz_cnt[3], {xe, xe}); end
      tick();
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_back_run: got busy %0b ready %0b want 0 1", busy, bus.in_ready); end
      checks++; if (xz_cnt !== 8'h00) begin failures++; $display("FAIL flush_cnt_cleared: got %0h want 0", xz_cnt); end
      bus.in_data    = '0;
      bus.in_data[0] = 9'h003;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_seq !== 4'd0) begin failures++; $display("FAIL flush_seq_restart: got valid %0b seq %0d want 1 0", bus.out_valid, bus.out_seq); end
      checks++; if (bus.out_par[0] !== 1'b0) begin failures++; $display("FAIL flush_new_par: got %0b want 0", bus.out_par[0]); end
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      bus.mode      = 1'b0;
      bus.in_data   = {4{x_word}};
      bus.in_valid  = 1'b1;
      tick();
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_buffered: got valid %0b busy %0b want 1 1", bus.out_valid, busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
      checks++; if (xz_cnt !== 8'h00) begin failures++; $display("FAIL mid_rst_cnt: got %0h want 0", xz_cnt); end
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_state: got busy %0b ready %0b want 0 1", busy, bus.in_ready); end
      bus.in_data  = '0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_seq !== 4'd0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_seq_restart: got valid %0b seq %0d want 1 0", bus.out_valid, bus.out_seq); end
   endtask

   initial begin
      x_word = 'x;
      ch1_x  = 9'b00000000x;
      ch1_z  = 9'b11111111z;
      rst    = 1'b1;
      flush  = 1'b0;
      bus.mode      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_xor();
      test_nand();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xz_parity_tracker.md
Name: xz_parity_tracker

Overview:
- Parametrised multi-channel 4-state bus monitor.
- Each accepted beat is reduced per channel to a gate-style parity bit plus an X/Z-present flag.
- Each beat's summary record is buffered in an output FIFO; per-channel X/Z occurrence counters accumulate across beats.
- Sits beside resolved/multi-driven nets in the design, giving a registered, 2-state view of their 4-state behaviour.

Parameters:
- NCH, 4, number of channels.
- W, 9, bits per channel (matches 3x3 packed words).
- DEPTH, 4, record FIFO entries (power of two, >=2).
- CNT_W, 8, width of each saturating X/Z counter.
- SEQ_W, 4, width of the beat sequence number.

Ports:
- clk  input  1  sole clock; everything on posedge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = XOR reduction, 1 = NAND reduction; sampled on the accepting beat.
- flush  input  1  single-cycle request to drain the FIFO and clear statistics.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat may be accepted.
- in_data  input  NCH*W  4-state logic [NCH-1:0][W-1:0].
- out_valid  output  1  record available.
- out_ready  input  1  consumer takes record.
- out_par  output  NCH  per-channel reduced bit, 2-state.
- out_xz  output  NCH  per-channel flag: some bit was X or Z.
- out_seq  output  SEQ_W  sequence number of the record.
- xz_cnt  output  NCH*CNT_W  per-channel saturating X/Z beat counters.
- busy  output  1  high when state != RUN or the FIFO is non-empty.

Behaviour:
- Reset: state RUN, FIFO empty, seq=0, xz_cnt all 0, out_valid=0, out_par/out_xz/out_seq=0, busy=0. Reset mid-operation discards all buffered records.
- in_ready = (state==RUN) && !full. A full FIFO does not accept a beat in the same cycle it pops (no pop-through).
- Accept = in_valid && in_ready.
- Per-channel reduction on accept:
  - xz flag = any bit X or Z.
  - Mode 0: XOR of all W bits, with X/Z bits mapped to 0.
  - Mode 1: NAND of all W bits, with X/Z bits mapped to 1.
  - Result is always 0/1, never X.
- On accept, record {par, xz, seq} is pushed, seq increments modulo 2^SEQ_W (wraps 2^SEQ_W-1 -> 0), and xz_cnt[c] increments for each flagged channel, saturating at all-ones.
- Latency: record is visible on out_* the cycle after accept; the FIFO is first-word-fall-through.
- Output: pop = out_valid && out_ready. out_* stay stable while out_valid && !out_ready. out_* are 0 whenever out_valid=0.
- Simultaneous push+pop with FIFO not full: both happen, occupancy unchanged.
- State machine:
  - RUN: flush -> DRAIN.
  - DRAIN: in_ready=0; pops continue; FIFO empty -> CLEAR.
  - CLEAR: one cycle; seq=0, xz_cnt=0; -> RUN.
- flush in RUN with the FIFO already empty still passes through DRAIN for one cycle, then CLEAR.
- flush asserted in DRAIN or CLEAR is ignored.
- A beat accepted in the same cycle flush is seen in RUN is kept, and drains before CLEAR.

Decomposition:
- Package xz_tracker_pkg holds:
  - state_e enum {RUN, DRAIN, CLEAR};
  - record_t packed struct {par, xz, seq};
  - reduction functions red_xor and red_nand, each with X/Z mapping, plus is_xz.
- Sub-module sync_fifo (parametrised width/depth, FWFT, full/empty flags) holds the records; the top holds the FSM, counters and reductions.

Test Plan:
1. Reset, then mode 0, one beat ch0=9'b000000111, ch1=9'b00000000x, others 0 -> next cycle out_valid=1, out_par[0]=1, out_par[1]=0, out_xz=4'b0010, out_seq=0; xz_cnt[1]=1.
2. Mode 1, ch0=9'h1FF, ch1=9'b11111111z -> out_par[0]=0, out_par[1]=0, out_xz[1]=1.
3. out_ready=0, push 5 beats with DEPTH=4 -> in_ready drops after 4 accepts; release out_ready -> records seq 0..3 in order, then beat 5 accepted as seq 4.
4. Push 17 beats with SEQ_W=4 -> seq wraps 15 -> 0. With CNT_W=2, 5 all-X beats -> xz_cnt saturates at 3.
5. Hold 3 records, pulse flush with out_ready=1 -> in_ready=0 and busy=1 until the FIFO is empty; one CLEAR cycle; then xz_cnt=0, next record seq=0.
6. Assert rst with 2 records buffered -> next cycle out_valid=0, xz_cnt=0, busy=0, in_ready=1.
